// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one sequential shift-add multiplier between two
// requesters. It picks a requester round-robin, latches its operands, pulses
// mul_init, then waits for mul_done (or a timeout). The product goes back on a
// shared result bus with a one-cycle per-requester strobe. Zero operands
// bypass the multiplier entirely.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   reqN_valid/md/mr      requester N operation (held until reqN_ready)
//   reqN_ready            requester N accepted this cycle (combinational)
//   rspN_valid            one-cycle response strobe for requester N
//   rsp_pp, rsp_err       registered product / timeout flag (shared)
//   busy                  arbiter not in IDLE
//   mul_init/md/mr        start pulse and latched operands to the multiplier
//   mul_done, mul_pp      multiplier completion and product
module mul_arbiter #(
  parameter int WIDTH   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_md,
  input  logic [WIDTH-1:0]   req0_mr,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_md,
  input  logic [WIDTH-1:0]   req1_mr,
  output logic               req1_ready,
  output logic               rsp0_valid,
  output logic               rsp1_valid,
  output logic [2*WIDTH-1:0] rsp_pp,
  output logic               rsp_err,
  output logic               busy,
  output logic               mul_init,
  output logic [WIDTH-1:0]   mul_md,
  output logic [WIDTH-1:0]   mul_mr,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_pp
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_r;
  logic                 last_grant_r;
  logic                 grant_id_r;
  logic [CW-1:0]        cnt_r;
  logic                 rsp0_valid_r;
  logic                 rsp1_valid_r;
  logic [2*WIDTH-1:0]   rsp_pp_r;
  logic                 rsp_err_r;
  logic                 mul_init_r;
  logic [WIDTH-1:0]     mul_md_r;
  logic [WIDTH-1:0]     mul_mr_r;

  logic                 grant_any_s;
  logic                 grant_id_s;
  logic [WIDTH-1:0]     sel_md_s;
  logic [WIDTH-1:0]     sel_mr_s;
  logic                 zero_s;

  // Round-robin grant while idle; on a tie the requester not served last wins.
  // Reset masks the grant so ready is low during the reset cycle.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = 1'b0;
    if (state_r == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant_any_s = 1'b1;
        grant_id_s  = ~last_grant_r;
      end else if (req0_valid) begin
        grant_any_s = 1'b1;
        grant_id_s  = 1'b0;
      end else if (req1_valid) begin
        grant_any_s = 1'b1;
        grant_id_s  = 1'b1;
      end else begin
        grant_any_s = 1'b0;
        grant_id_s  = 1'b0;
      end
    end else begin
      grant_any_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Operand mux for the granted requester and the zero-operand shortcut test.
  always_comb begin
    sel_md_s = req0_md;
    sel_mr_s = req0_mr;
    if (grant_id_s) begin
      sel_md_s = req1_md;
      sel_mr_s = req1_mr;
    end else begin
      sel_md_s = req0_md;
      sel_mr_s = req0_mr;
    end
    zero_s = (sel_md_s == {WIDTH{1'b0}}) || (sel_mr_s == {WIDTH{1'b0}});
  end

  // Arbiter FSM with registered response, init pulse and operand latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      grant_id_r   <= 1'b0;
      cnt_r        <= {CW{1'b0}};
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp_pp_r     <= {(2*WIDTH){1'b0}};
      rsp_err_r    <= 1'b0;
      mul_init_r   <= 1'b0;
      mul_md_r     <= {WIDTH{1'b0}};
      mul_mr_r     <= {WIDTH{1'b0}};
    end else begin
      // Strobes default low; they are raised only on the entering transition.
      mul_init_r   <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            mul_md_r   <= sel_md_s;
            mul_mr_r   <= sel_mr_s;
            grant_id_r <= grant_id_s;
            if (zero_s) begin
              rsp_pp_r     <= {(2*WIDTH){1'b0}};
              rsp_err_r    <= 1'b0;
              rsp0_valid_r <= ~grant_id_s;
              rsp1_valid_r <= grant_id_s;
              state_r      <= RESP;
            end else begin
              mul_init_r <= 1'b1;
              state_r    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_r   <= CW'(TIMEOUT);
          state_r <= WAIT;
        end
        WAIT: begin
          // done beats an expiring counter in the same cycle
          if (mul_done) begin
            rsp_pp_r     <= mul_pp;
            rsp_err_r    <= 1'b0;
            rsp0_valid_r <= ~grant_id_r;
            rsp1_valid_r <= grant_id_r;
            state_r      <= RESP;
          end else if (cnt_r == CW'(1)) begin
            rsp_pp_r     <= {(2*WIDTH){1'b0}};
            rsp_err_r    <= 1'b1;
            rsp0_valid_r <= ~grant_id_r;
            rsp1_valid_r <= grant_id_r;
            cnt_r        <= {CW{1'b0}};
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        RESP: begin
          last_grant_r <= grant_id_r;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = grant_any_s & ~grant_id_s;
  assign req1_ready = grant_any_s & grant_id_s;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp_pp     = rsp_pp_r;
  assign rsp_err    = rsp_err_r;
  assign busy       = (state_r != IDLE);
  assign mul_init   = mul_init_r;
  assign mul_md     = mul_md_r;
  assign mul_mr     = mul_mr_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: emulated multiplier, directed scenarios with literal
// expectations, then randomized traffic against a timing-level model that
// predicts every output from accept/init/response cycle numbers.
module tb_mul_arbiter;

  localparam int W   = 3;
  localparam int TO  = 15;
  localparam int BIG = 32'h3fffffff;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0]   req0_md = '0, req0_mr = '0, req1_md = '0, req1_mr = '0;
  logic           mul_done = 1'b0;
  logic [2*W-1:0] mul_pp = '0;
  logic           req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, busy, mul_init;
  logic [2*W-1:0] rsp_pp;
  logic [W-1:0]   mul_md, mul_mr;

  mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_md(req0_md), .req0_mr(req0_mr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_md(req1_md), .req1_mr(req1_mr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_pp(rsp_pp), .rsp_err(rsp_err),
    .busy(busy), .mul_init(mul_init), .mul_md(mul_md), .mul_mr(mul_mr),
    .mul_done(mul_done), .mul_pp(mul_pp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // A transaction is described only by its accept cycle, its init cycle and
  // its response cycle; every output follows from those numbers.
  int             t_init = -100;
  int             t_rsp  = -1;
  bit             m_id = 1'b0, m_last = 1'b1;
  logic [2*W-1:0] pend_pp = '0, cur_pp = '0;
  logic           pend_err = 1'b0, cur_err = 1'b0;
  logic [W-1:0]   cur_md = '0, cur_mr = '0;
  bit             e_r0, e_r1, idle;
  logic [W-1:0]   a_md, a_mr;
  int             c;

  always @(negedge clk) begin
    c = cyc;
    if (c == t_rsp) begin
      cur_pp  = pend_pp;
      cur_err = pend_err;
    end
    idle = (c > t_rsp);
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (idle && !reset) begin
      if (req0_valid && req1_valid) begin
        if (m_last) e_r0 = 1'b1; else e_r1 = 1'b1;
      end else if (req0_valid) e_r0 = 1'b1;
      else if (req1_valid) e_r1 = 1'b1;
    end
    chk("ready0", req0_ready, e_r0);
    chk("ready1", req1_ready, e_r1);
    if (!reset) begin
      chk("busy", busy, !idle);
      chk("mul_init", mul_init, c == t_init);
      chk("rsp0_valid", rsp0_valid, (c == t_rsp) && !m_id);
      chk("rsp1_valid", rsp1_valid, (c == t_rsp) && m_id);
      chk("rsp_pp", rsp_pp, cur_pp);
      chk("rsp_err", rsp_err, cur_err);
      chk("mul_md", mul_md, cur_md);
      chk("mul_mr", mul_mr, cur_mr);
    end
    if (reset) begin
      t_rsp = c; t_init = -100; m_last = 1'b1;
      cur_pp = '0; cur_err = 1'b0; cur_md = '0; cur_mr = '0;
    end else begin
      if (c == t_rsp) m_last = m_id;
      if (e_r0 || e_r1) begin
        m_id = e_r1;
        a_md = e_r1 ? req1_md : req0_md;
        a_mr = e_r1 ? req1_mr : req0_mr;
        cur_md = a_md;
        cur_mr = a_mr;
        if (a_md == 0 || a_mr == 0) begin
          t_init = -100; t_rsp = c + 1; pend_pp = '0; pend_err = 1'b0;
        end else begin
          t_init = c + 1; t_rsp = BIG;
        end
      end else if (t_rsp == BIG && c > t_init && c <= t_init + TO) begin
        if (mul_done) begin
          t_rsp = c + 1; pend_pp = mul_pp; pend_err = 1'b0;
        end else if (c == t_init + TO) begin
          t_rsp = c + 1; pend_pp = '0; pend_err = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus: requesters and emulated multiplier ----------------
  bit             rand_mode = 1'b0;
  int             dly = 8;
  int             sched = -1;
  logic [2*W-1:0] prod = '0;
  bit             pend0 = 1'b0, pend1 = 1'b0;
  int             s_cyc;
  logic           s_rdy0, s_rdy1, s_rsp0, s_rsp1, s_init, s_err, s_busy;
  logic [W-1:0]   s_md, s_mr;
  logic [2*W-1:0] s_pp;
  int             n_init, n_rdy0, n_rdy1;

  // Snapshot cycle k at its negedge, then set up inputs for cycle k+1.
  task automatic cycle();
    @(negedge clk);
    s_cyc = cyc; s_rdy0 = req0_ready; s_rdy1 = req1_ready;
    s_rsp0 = rsp0_valid; s_rsp1 = rsp1_valid; s_init = mul_init;
    s_pp = rsp_pp; s_err = rsp_err; s_busy = busy; s_md = mul_md; s_mr = mul_mr;
    @(posedge clk);
    #1;
    if (s_init === 1'b1) begin
      sched = s_cyc + (rand_mode ? int'($urandom_range(1, 20)) : dly);
      prod  = s_md * s_mr;
    end
    if (cyc == sched) begin
      mul_done = 1'b1; mul_pp = prod; sched = -1;
    end else if (rand_mode && ($urandom % 24) == 0) begin
      mul_done = 1'b1; mul_pp = 6'($urandom);
    end else begin
      mul_done = 1'b0; mul_pp = 6'($urandom);
    end
    if (rand_mode) begin
      reset = (($urandom % 400) == 0);
      if (pend0 && s_rdy0) pend0 = 1'b0;
      else if (pend0 && ($urandom % 40) == 0) pend0 = 1'b0;
      if (pend1 && s_rdy1) pend1 = 1'b0;
      else if (pend1 && ($urandom % 40) == 0) pend1 = 1'b0;
      if (!pend0) begin
        pend0 = (($urandom % 3) == 0);
        req0_md = 3'($urandom); req0_mr = 3'($urandom);
      end
      if (!pend1) begin
        pend1 = (($urandom % 3) == 0);
        req1_md = 3'($urandom); req1_mr = 3'($urandom);
      end
      req0_valid = pend0;
      req1_valid = pend1;
    end else begin
      if (s_rdy0) begin req0_valid = 1'b0; req0_md = req0_md + 3'd1; end
      if (s_rdy1) begin req1_valid = 1'b0; req1_mr = req1_mr + 3'd1; end
    end
  endtask

  task automatic wait_rsp(input int t0, input string nm, output int lat, output int id,
                          output logic [2*W-1:0] pp, output logic err);
    bit got;
    got = 1'b0; lat = -1; id = -1; pp = '0; err = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      cycle();
      n_init += int'(s_init); n_rdy0 += int'(s_rdy0); n_rdy1 += int'(s_rdy1);
      if (s_rsp0 || s_rsp1) begin
        got = 1'b1; lat = s_cyc - t0; id = int'(s_rsp1); pp = s_pp; err = s_err;
      end
    end
    chk({nm, "_seen"}, 32'(got), 32'd1);
  endtask

  int             lat, id, t0, cnt;
  logic [2*W-1:0] pp;
  logic           err;

  initial begin
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    // single op 3x5, done 8 cycles after init
    n_init = 0; n_rdy0 = 0; n_rdy1 = 0; dly = 8;
    req0_valid = 1'b1; req0_md = 3'd3; req0_mr = 3'd5; t0 = cyc;
    wait_rsp(t0, "single", lat, id, pp, err);
    chk("single_lat", lat, 10); chk("single_id", id, 0);
    chk("single_pp", pp, 6'd15); chk("single_err", err, 1'b0);
    chk("single_inits", n_init, 1); chk("single_ready", n_rdy0, 1);

    // arbitration after reset: req0 first, then req1, then req0 again
    reset = 1'b1; cycle(); reset = 1'b0;
    n_rdy0 = 0; n_rdy1 = 0; dly = 3;
    req0_valid = 1'b1; req0_md = 3'd7; req0_mr = 3'd7;
    req1_valid = 1'b1; req1_md = 3'd2; req1_mr = 3'd3; t0 = cyc;
    wait_rsp(t0, "arb1", lat, id, pp, err);
    chk("arb1_id", id, 0); chk("arb1_pp", pp, 6'd49); chk("arb1_lat", lat, 5);
    wait_rsp(t0, "arb2", lat, id, pp, err);
    chk("arb2_id", id, 1); chk("arb2_pp", pp, 6'd6);
    chk("arb_ready0", n_rdy0, 1); chk("arb_ready1", n_rdy1, 1);
    req0_valid = 1'b1; req0_md = 3'd7; req0_mr = 3'd7;
    req1_valid = 1'b1; req1_md = 3'd2; req1_mr = 3'd3;
    wait_rsp(cyc, "arb3", lat, id, pp, err);
    chk("arb3_id", id, 0); chk("arb3_pp", pp, 6'd49);
    wait_rsp(cyc, "arb4", lat, id, pp, err);
    chk("arb4_id", id, 1);

    // zero shortcut on requester 1
    n_init = 0; n_rdy1 = 0;
    req1_valid = 1'b1; req1_md = 3'd0; req1_mr = 3'd6; t0 = cyc;
    wait_rsp(t0, "zero", lat, id, pp, err);
    chk("zero_lat", lat, 1); chk("zero_id", id, 1); chk("zero_pp", pp, 6'd0);
    chk("zero_err", err, 1'b0); chk("zero_inits", n_init, 0); chk("zero_ready", n_rdy1, 1);

    // timeout, then a normal op
    dly = 100;
    req0_valid = 1'b1; req0_md = 3'd2; req0_mr = 3'd3; t0 = cyc;
    wait_rsp(t0, "tmo", lat, id, pp, err);
    chk("tmo_lat", lat, 17); chk("tmo_err", err, 1'b1); chk("tmo_pp", pp, 6'd0);
    dly = 4;
    req1_valid = 1'b1; req1_md = 3'd3; req1_mr = 3'd2; t0 = cyc;
    wait_rsp(t0, "post_tmo", lat, id, pp, err);
    chk("post_tmo_lat", lat, 6); chk("post_tmo_err", err, 1'b0); chk("post_tmo_pp", pp, 6'd6);

    // reset while waiting; the stale done must not produce a response
    dly = 10;
    req0_valid = 1'b1; req0_md = 3'd3; req0_mr = 3'd3;
    repeat (4) cycle();
    reset = 1'b1; cycle(); reset = 1'b0; cycle();
    chk("rst_busy", s_busy, 1'b0); chk("rst_init", s_init, 1'b0);
    chk("rst_rsp", s_rsp0 | s_rsp1, 1'b0); chk("rst_pp", s_pp, 6'd0);
    chk("rst_err", s_err, 1'b0); chk("rst_md", s_md, 3'd0); chk("rst_mr", s_mr, 3'd0);
    cnt = 0;
    repeat (15) begin cycle(); cnt += int'(s_rsp0 | s_rsp1); end
    chk("rst_no_rsp", cnt, 0);
    dly = 2;
    req0_valid = 1'b1; req0_md = 3'd2; req0_mr = 3'd2; t0 = cyc;
    wait_rsp(t0, "post_rst", lat, id, pp, err);
    chk("post_rst_lat", lat, 4); chk("post_rst_id", id, 0); chk("post_rst_pp", pp, 6'd4);

    // done on the counter-expiry cycle
    dly = 15;
    req1_valid = 1'b1; req1_md = 3'd5; req1_mr = 3'd7; t0 = cyc;
    wait_rsp(t0, "tie", lat, id, pp, err);
    chk("tie_lat", lat, 17); chk("tie_err", err, 1'b0); chk("tie_pp", pp, 6'd35);

    // randomized traffic against the model
    rand_mode = 1'b1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
    repeat (40) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
